// File: rtl/memoria_dados_bytes_if.sv
// Request/response bundle between the pipeline and the byte-addressable data memory.
interface memoria_dados_bytes_if;
    logic [31:0] Resultado;
    logic [31:0] DadosEscrita;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Erro;

    modport master (
        output Resultado, DadosEscrita, MemRead, MemWrite, Size, Unsigned,
        input  ReadData, Ready, Erro
    );

    modport slave (
        input  Resultado, DadosEscrita, MemRead, MemWrite, Size, Unsigned,
        output ReadData, Ready, Erro
    );
endinterface

// File: rtl/memoria_dados_bytes.sv
// Byte-addressable little-endian data memory with fixed-latency request handling.
// The memory is four byte-wide lane arrays. Each lane has a registered read port
// that samples the incoming address while idle. The addressed word is therefore
// already held when a request is accepted, and loads can be served at commit
// (including the post-store view for combined read+write requests).
module memoria_dados_bytes #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 1
) (
    input  logic Clock,
    input  logic Reset,
    memoria_dados_bytes_if.slave bus
);

    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       lane_reg;
    logic [31:0]      wdata_reg;
    logic [1:0]       size_reg;
    logic             uns_reg;
    logic             rd_reg;
    logic             wr_reg;
    logic             fault_reg;
    logic [31:0]      rdata_reg, rdata_next;
    logic             ready_reg, ready_next;
    logic             erro_reg, erro_next;

    logic             req;
    logic             in_range;
    logic             in_fault;
    logic             accept;
    logic             commit;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      merged_word;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;

    assign req      = bus.MemRead | bus.MemWrite;
    assign in_range = (bus.Resultado[31:2] < 30'(DEPTH));
    assign rd_idx   = bus.Resultado[IDX_W+1:2];
    assign rd_en    = (state_reg == IDLE) && in_range;

    // Classify the incoming request as faulted (misaligned, illegal size or out of range)
    always_comb begin
        in_fault = 1'b0;
        case (bus.Size)
            2'b00:   in_fault = 1'b0;
            2'b01:   in_fault = bus.Resultado[0];
            2'b10:   in_fault = |bus.Resultado[1:0];
            default: in_fault = 1'b1;
        endcase
        if (!in_range) begin
            in_fault = 1'b1;
        end
    end

    // Byte lanes: per-lane store enable, store byte, storage and registered read
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            logic [7:0] mem_lane [DEPTH];
            logic [7:0] q_reg;
            logic       lane_sel;
            logic       store_en;
            logic [7:0] wbyte;

            // Decide whether this lane is touched by the latched store and with which byte
            always_comb begin
                lane_sel = 1'b0;
                wbyte    = wdata_reg[8*gi +: 8];
                case (size_reg)
                    2'b00: begin
                        lane_sel = (lane_reg == LANE);
                        wbyte    = wdata_reg[7:0];
                    end
                    2'b01: begin
                        lane_sel = (lane_reg[1] == LANE[1]);
                        wbyte    = LANE[0] ? wdata_reg[15:8] : wdata_reg[7:0];
                    end
                    2'b10: begin
                        lane_sel = 1'b1;
                        wbyte    = wdata_reg[8*gi +: 8];
                    end
                    default: begin
                        lane_sel = 1'b0;
                        wbyte    = wdata_reg[8*gi +: 8];
                    end
                endcase
                store_en = wr_reg && !fault_reg && lane_sel;
            end

            // Commit the store byte; sample the addressed byte while idle
            always_ff @(posedge Clock) begin
                if (commit && !Reset && store_en) begin
                    mem_lane[idx_reg] <= wbyte;
                end
                if (rd_en) begin
                    q_reg <= mem_lane[rd_idx];
                end
            end

            assign merged_word[8*gi +: 8] = store_en ? wbyte : q_reg;
        end
    endgenerate

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: accept while idle, return to idle when the counter expires
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (cnt_reg == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: acceptance, commit strobe and the next values of the registered results
    always_comb begin
        accept     = (state_reg == IDLE) && req;
        commit     = (state_reg == BUSY) && (cnt_reg == 4'd1);
        ready_next = 1'b0;
        erro_next  = 1'b0;
        rdata_next = rdata_reg;
        byte_val   = merged_word[{lane_reg, 3'b000} +: 8];
        half_val   = lane_reg[1] ? merged_word[31:16] : merged_word[15:0];
        if (commit) begin
            ready_next = 1'b1;
            erro_next  = fault_reg;
            if (rd_reg) begin
                if (fault_reg) begin
                    rdata_next = 32'd0;
                end else if (wr_reg) begin
                    // Combined read+write returns the whole post-store word
                    rdata_next = merged_word;
                end else begin
                    case (size_reg)
                        2'b00:   rdata_next = uns_reg ? {24'd0, byte_val}
                                                      : {{24{byte_val[7]}}, byte_val};
                        2'b01:   rdata_next = uns_reg ? {16'd0, half_val}
                                                      : {{16{half_val[15]}}, half_val};
                        default: rdata_next = merged_word;
                    endcase
                end
            end
        end
    end

    // Request latch, latency counter and registered results
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_reg   <= 4'd0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            fault_reg <= 1'b0;
            rdata_reg <= 32'd0;
            ready_reg <= 1'b0;
            erro_reg  <= 1'b0;
        end else begin
            ready_reg <= ready_next;
            erro_reg  <= erro_next;
            rdata_reg <= rdata_next;
            if (accept) begin
                cnt_reg   <= 4'(LATENCY);
                idx_reg   <= rd_idx;
                lane_reg  <= bus.Resultado[1:0];
                wdata_reg <= bus.DadosEscrita;
                size_reg  <= bus.Size;
                uns_reg   <= bus.Unsigned;
                rd_reg    <= bus.MemRead;
                wr_reg    <= bus.MemWrite;
                fault_reg <= in_fault;
            end else if (state_reg == BUSY) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
        end
    end

    assign bus.ReadData = rdata_reg;
    assign bus.Ready    = ready_reg;
    assign bus.Erro     = erro_reg;

endmodule

// File: tb/tb_memoria_dados_bytes.sv
// Directed bench: three instances (LATENCY 1, 3, 4) receive identical requests.
module tb_memoria_dados_bytes;

    logic        Clock;
    logic        Reset;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic        t_rd;
    logic        t_wr;
    logic [1:0]  t_size;
    logic        t_uns;

    int total = 0;
    int bad   = 0;

    memoria_dados_bytes_if b1 ();
    memoria_dados_bytes_if b3 ();
    memoria_dados_bytes_if b4 ();

    assign b1.Resultado = t_addr;  assign b1.DadosEscrita = t_wdata;
    assign b1.MemRead   = t_rd;    assign b1.MemWrite     = t_wr;
    assign b1.Size      = t_size;  assign b1.Unsigned     = t_uns;
    assign b3.Resultado = t_addr;  assign b3.DadosEscrita = t_wdata;
    assign b3.MemRead   = t_rd;    assign b3.MemWrite     = t_wr;
    assign b3.Size      = t_size;  assign b3.Unsigned     = t_uns;
    assign b4.Resultado = t_addr;  assign b4.DadosEscrita = t_wdata;
    assign b4.MemRead   = t_rd;    assign b4.MemWrite     = t_wr;
    assign b4.Size      = t_size;  assign b4.Unsigned     = t_uns;

    memoria_dados_bytes #(.DEPTH(128), .LATENCY(1)) u_l1 (.Clock(Clock), .Reset(Reset), .bus(b1));
    memoria_dados_bytes #(.DEPTH(128), .LATENCY(3)) u_l3 (.Clock(Clock), .Reset(Reset), .bus(b3));
    memoria_dados_bytes #(.DEPTH(128), .LATENCY(4)) u_l4 (.Clock(Clock), .Reset(Reset), .bus(b4));

    // index 0 = LATENCY 1, 1 = LATENCY 3, 2 = LATENCY 4
    logic [2:0]  rdy;
    logic [2:0]  err;
    logic [31:0] rdat [3];
    int          lat  [3] = '{1, 3, 4};
    logic [31:0] model_rd [3];

    assign rdy = {b4.Ready, b3.Ready, b1.Ready};
    assign err = {b4.Erro,  b3.Erro,  b1.Erro};
    assign rdat[0] = b1.ReadData;
    assign rdat[1] = b3.ReadData;
    assign rdat[2] = b4.ReadData;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_dat;
        logic        exp_err;
        logic        chk_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_dat, input logic exp_err, input logic chk_dat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.exp_dat = exp_dat; v.exp_err = exp_err; v.chk_dat = chk_dat;
        vecs.push_back(v);
    endtask

    // One request to all instances; checks Ready timing, Erro and ReadData per masked instance
    task automatic run_txn(input string name, input vec_t v, input logic [2:0] mask);
        int          pulses [3];
        int          at     [3];
        logic        gerr   [3];
        logic [31:0] gdat   [3];
        int          stray;
        stray = 0;
        for (int d = 0; d < 3; d++) begin
            pulses[d] = 0; at[d] = -1; gerr[d] = 1'bx; gdat[d] = 32'hx;
        end
        @(negedge Clock);
        t_addr = v.addr; t_wdata = v.wdata; t_size = v.size; t_uns = v.uns;
        t_rd = v.rd; t_wr = v.wr;
        @(posedge Clock);
        @(negedge Clock);
        t_rd = 1'b0; t_wr = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge Clock);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (rdy[d]) begin
                    pulses[d]++; at[d] = c; gerr[d] = err[d]; gdat[d] = rdat[d];
                end else if (err[d]) begin
                    stray++;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (mask[d]) begin
                chk($sformatf("%s ready_cycle L%0d", name, lat[d]),
                    (pulses[d] == 1) ? 32'(at[d]) : 32'hFFFF_0000 | 32'(pulses[d]), 32'(lat[d]));
                chk($sformatf("%s erro L%0d", name, lat[d]), {31'd0, gerr[d]}, {31'd0, v.exp_err});
                if (v.rd) model_rd[d] = v.exp_dat;
                if (v.chk_dat) chk($sformatf("%s readdata L%0d", name, lat[d]), gdat[d], model_rd[d]);
            end
        end
        chk($sformatf("%s stray_erro", name), 32'(stray), 32'd0);
        $display("txn %s rd=%0b wr=%0b size=%0d uns=%0b addr=%h wdata=%h -> L1 %h L3 %h L4 %h",
                 name, v.rd, v.wr, v.size, v.uns, v.addr, v.wdata, gdat[0], gdat[1], gdat[2]);
    endtask

    vec_t v;

    initial begin
        Reset = 1'b1; t_addr = '0; t_wdata = '0; t_rd = 1'b0; t_wr = 1'b0; t_size = 2'b10; t_uns = 1'b0;
        for (int d = 0; d < 3; d++) model_rd[d] = 32'd0;

        //   rd wr size  uns addr          wdata          exp_dat        err chk
        add(0, 1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 1);
        add(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1);
        add(0, 1, 2'b10, 0, 32'h0000_0020, 32'h0000_0000, 32'h0,         0, 1);
        add(0, 1, 2'b00, 0, 32'h0000_0023, 32'h1234_5680, 32'h0,         0, 1);
        add(1, 0, 2'b00, 0, 32'h0000_0023, 32'h0,         32'hFFFF_FF80, 0, 1);
        add(1, 0, 2'b00, 1, 32'h0000_0023, 32'h0,         32'h0000_0080, 0, 1);
        add(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0,         32'h8000_0000, 0, 1);
        add(0, 1, 2'b10, 0, 32'h0000_0050, 32'h1122_3344, 32'h0,         0, 1);
        add(1, 1, 2'b01, 0, 32'h0000_0052, 32'h5555_AAAA, 32'hAAAA_3344, 0, 1);
        add(1, 0, 2'b10, 0, 32'h0000_0050, 32'h0,         32'hAAAA_3344, 0, 1);
        add(1, 0, 2'b00, 0, 32'h0000_0010, 32'h0,         32'hFFFF_FFEF, 0, 1);
        add(1, 0, 2'b00, 1, 32'h0000_0011, 32'h0,         32'h0000_00BE, 0, 1);
        add(1, 0, 2'b01, 1, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 0, 1);
        add(1, 0, 2'b01, 0, 32'h0000_0012, 32'h0,         32'hFFFF_DEAD, 0, 1);
        add(1, 0, 2'b10, 1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1);
        add(1, 0, 2'b10, 0, 32'h0000_0002, 32'h0,         32'h0,         1, 1);
        add(1, 0, 2'b01, 0, 32'h0000_0001, 32'h0,         32'h0,         1, 1);
        add(1, 0, 2'b10, 0, 32'h0000_0200, 32'h0,         32'h0,         1, 1);
        add(1, 0, 2'b11, 0, 32'h0000_0010, 32'h0,         32'h0,         1, 1);
        add(1, 0, 2'b00, 0, 32'h0000_0200, 32'h0,         32'h0,         1, 1);
        add(0, 1, 2'b10, 0, 32'h0000_0012, 32'h0,         32'h0,         1, 0);
        add(0, 1, 2'b11, 0, 32'h0000_0010, 32'h0,         32'h0,         1, 0);
        add(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1);
        add(0, 1, 2'b10, 0, 32'h0000_0030, 32'hFFFF_FFFF, 32'h0,         0, 0);
        add(0, 1, 2'b01, 0, 32'h0000_0032, 32'h0001_8001, 32'h0,         0, 0);
        add(1, 0, 2'b10, 0, 32'h0000_0030, 32'h0,         32'h8001_FFFF, 0, 1);
        add(1, 0, 2'b01, 0, 32'h0000_0032, 32'h0,         32'hFFFF_8001, 0, 1);
        add(1, 0, 2'b01, 1, 32'h0000_0030, 32'h0,         32'h0000_FFFF, 0, 1);
        add(0, 1, 2'b00, 0, 32'h0000_01FF, 32'hAAAA_AA7F, 32'h0,         0, 1);
        add(1, 0, 2'b00, 0, 32'h0000_01FF, 32'h0,         32'h0000_007F, 0, 1);

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset readdata L%0d", lat[d]), rdat[d], 32'd0);
            chk($sformatf("reset ready L%0d", lat[d]), {31'd0, rdy[d]}, 32'd0);
            chk($sformatf("reset erro L%0d", lat[d]), {31'd0, err[d]}, 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i], 3'b111);
        end

        // LATENCY 4: held second request is ignored while busy and accepted right after completion
        @(negedge Clock);
        t_addr = 32'h10; t_size = 2'b10; t_uns = 1'b0; t_rd = 1'b1; t_wr = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        t_addr = 32'h50;
        for (int c = 1; c <= 9; c++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("hold ready c%0d", c), {31'd0, rdy[2]}, (c == 4 || c == 9) ? 32'd1 : 32'd0);
            if (c == 4) chk("hold first readdata", rdat[2], 32'hDEAD_BEEF);
            if (c == 9) chk("hold second readdata", rdat[2], 32'hAAAA_3344);
            if (c == 5) begin
                @(negedge Clock);
                t_rd = 1'b0;
            end
        end
        $display("txn hold L4 first=10 second=50 readdata=%h", rdat[2]);
        repeat (8) @(posedge Clock);

        // Reset wins over a request at the same edge
        @(negedge Clock);
        Reset = 1'b1; t_addr = 32'h10; t_size = 2'b10; t_rd = 1'b1;
        @(negedge Clock);
        Reset = 1'b0; t_rd = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("rstprio ready c%0d", c), {29'd0, rdy}, 32'd0);
        end
        for (int d = 0; d < 3; d++) model_rd[d] = 32'd0;
        $display("txn reset_priority read addr=10 suppressed");

        // LATENCY 3: reset during BUSY aborts the store
        v = '{rd: 1'b0, wr: 1'b1, size: 2'b10, uns: 1'b0, addr: 32'h40,
              wdata: 32'hCAFE_F00D, exp_dat: 32'h0, exp_err: 1'b0, chk_dat: 1'b1};
        run_txn("pre_abort", v, 3'b111);
        @(negedge Clock);
        t_addr = 32'h40; t_wdata = 32'h1234_5678; t_size = 2'b10; t_wr = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        t_wr = 1'b0;
        @(posedge Clock);
        #1;
        chk("abort ready k+1", {31'd0, rdy[1]}, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("abort ready k+2", {31'd0, rdy[1]}, 32'd0);
        chk("abort readdata k+2", rdat[1], 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("abort ready k+%0d", c), {31'd0, rdy[1]}, 32'd0);
        end
        for (int d = 0; d < 3; d++) model_rd[d] = 32'd0;
        $display("txn abort store addr=40 wdata=12345678 reset at k+2");
        v = '{rd: 1'b1, wr: 1'b0, size: 2'b10, uns: 1'b0, addr: 32'h40,
              wdata: 32'h0, exp_dat: 32'hCAFE_F00D, exp_err: 1'b0, chk_dat: 1'b1};
        run_txn("post_abort", v, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
